// File: rtl/spi_memory_controller.sv
// spi_memory_controller: 16-bit word memory bus to SPI serial memory bridge (mode 0, 40-bit frames)
module spi_memory_controller #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [15:0] data_in,
  input  logic        write_enable,
  input  logic        start,
  output logic [15:0] data_out,
  output logic        busy,
  output logic        ready,
  output logic        spi_cs,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  typedef enum logic [2:0] {IDLE, START, SHIFT, STOP, DONE} state_t;
  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
  state_t state, next;
  logic [7:0] cnt;
  logic [5:0] bitc;
  logic ph, ph_n, phase_end;
  logic [39:0] frame;
  logic [15:0] rx;
  logic wr;
  assign phase_end = cnt == LAST;
  assign busy = state inside {START, SHIFT, STOP};
  assign ready = state == DONE;
  assign spi_cs = !(state == START || state == SHIFT);
  assign spi_clk = ph;
  assign spi_mosi = frame[39];
  // state register; reset aborts any transaction immediately
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  // next-state and SPI clock phase decode
  always_comb begin
    next = state;
    unique case (state)
      IDLE:  next = start ? START : IDLE;
      START: next = phase_end ? SHIFT : START;
      SHIFT: next = (phase_end && !ph && bitc == 6'd39) ? STOP : SHIFT;
      STOP:  next = phase_end ? DONE : STOP;
      DONE:  next = IDLE;
      default: next = IDLE;
    endcase
    ph_n = next != state ? next == SHIFT : (state == SHIFT && phase_end) ? !ph : ph;
  end
  // counters, frame shifter, receive shifter and read result
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      bitc <= '0;
      ph <= 1'b0;
      frame <= '0;
      rx <= '0;
      wr <= 1'b0;
      data_out <= '0;
    end else begin
      cnt <= (next != state || phase_end || state == IDLE || state == DONE) ? '0 : cnt + 8'd1;
      bitc <= next != state ? '0 : (state == SHIFT && phase_end && !ph) ? bitc + 6'd1 : bitc;
      ph <= ph_n;
      if (state == IDLE && start) begin
        frame <= {write_enable ? 8'h02 : 8'h03, address[14:0], 1'b0, write_enable ? data_in : 16'h0000};
        wr <= write_enable;
      end else if (ph && !ph_n) frame <= {frame[38:0], 1'b0};
      if (ph_n && !ph) rx <= {rx[14:0], spi_miso};
      if (state == STOP && next == DONE && !wr) data_out <= rx;
    end
endmodule

// File: tb/tb_spi_memory_controller.sv
// tb_spi_memory_controller: directed vectors against a behavioural SPI memory
module tb_spi_memory_controller;
  logic clk = 0, reset = 0;
  logic [15:0] address = 0, data_in = 0, data_out;
  logic write_enable = 0, start = 0, busy, ready, spi_cs, spi_clk, spi_mosi, spi_miso = 0;
  logic [1:0] sx = 0, bx, rx, cx, clx, mx;
  logic [15:0] d1, d5;
  int vecs = 0, errs = 0;
  logic [15:0] mem [0:32767];
  logic [39:0] cap;
  logic [15:0] oshift;
  int mbits = 0, frames = 0, readys = 0;

  always #5 clk = ~clk;

  spi_memory_controller #(.CLK_DIV(2)) dut (.clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .write_enable(write_enable), .start(start), .data_out(data_out), .busy(busy), .ready(ready),
    .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso));
  spi_memory_controller #(.CLK_DIV(1)) u1 (.clk(clk), .reset(reset), .address(16'h0001), .data_in(16'h0000),
    .write_enable(1'b0), .start(sx[0]), .data_out(d1), .busy(bx[0]), .ready(rx[0]),
    .spi_cs(cx[0]), .spi_clk(clx[0]), .spi_mosi(mx[0]), .spi_miso(1'b0));
  spi_memory_controller #(.CLK_DIV(5)) u5 (.clk(clk), .reset(reset), .address(16'h0001), .data_in(16'h0000),
    .write_enable(1'b0), .start(sx[1]), .data_out(d5), .busy(bx[1]), .ready(rx[1]),
    .spi_cs(cx[1]), .spi_clk(clx[1]), .spi_mosi(mx[1]), .spi_miso(1'b0));

  // SPI memory: command and address arrive MSB first, read data leaves on falling spi_clk
  always @(negedge spi_cs) begin
    mbits = 0;
    frames++;
    spi_miso = 0;
  end
  always @(posedge spi_clk) begin
    cap = {cap[38:0], spi_mosi};
    mbits++;
    if (mbits == 24 && cap[23:16] == 8'h03) oshift = mem[cap[15:1]];
    if (mbits == 40 && cap[39:32] == 8'h02) mem[cap[31:17]] = cap[15:0];
  end
  always @(negedge spi_clk)
    if (mbits >= 24) begin
      spi_miso = oshift[15];
      oshift = {oshift[14:0], 1'b0};
    end
  always @(negedge clk) if (ready) readys++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic txn(input logic [15:0] a, input logic [15:0] d, input logic w, output int lat);
    @(negedge clk);
    address = a; data_in = d; write_enable = w; start = 1;
    @(posedge clk);
    #1 start = 0; address = ~a; data_in = ~d; write_enable = ~w;
    check("busy_after_start", busy, 1);
    lat = 0;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = n + 1;
        break;
      end
    end
  endtask

  task automatic meas(input int k, output int lat, output int per);
    logic prev;
    int r1, r2;
    @(negedge clk);
    sx[k] = 1;
    @(posedge clk);
    #1 sx[k] = 0;
    prev = 0; r1 = -1; r2 = -1; lat = 0;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk);
      #1;
      if (clx[k] && !prev) begin
        if (r1 < 0) r1 = n;
        else if (r2 < 0) r2 = n;
      end
      prev = clx[k];
      if (rx[k]) begin
        lat = n + 1;
        break;
      end
    end
    per = r2 - r1;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] din;
    logic we;
    logic [39:0] frame;
    logic [15:0] dout;
  } vec_t;
  vec_t v[6];

  initial begin
    int lat, per, r0, f0;
    bit hit;
    v[0] = '{16'h0123, 16'h5555, 1'b0, {8'h03, 16'h0246, 16'h0000}, 16'hBEEF};
    v[1] = '{16'h7FFF, 16'h1234, 1'b1, {8'h02, 16'hFFFE, 16'h1234}, 16'hBEEF};
    v[2] = '{16'h8123, 16'h0000, 1'b0, {8'h03, 16'h0246, 16'h0000}, 16'hBEEF};
    v[3] = '{16'h7FFF, 16'hFFFF, 1'b0, {8'h03, 16'hFFFE, 16'h0000}, 16'h1234};
    v[4] = '{16'h0000, 16'hA5A5, 1'b1, {8'h02, 16'h0000, 16'hA5A5}, 16'h1234};
    v[5] = '{16'h0000, 16'h0000, 1'b0, {8'h03, 16'h0000, 16'h0000}, 16'hA5A5};
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[15'h0123] = 16'hBEEF;
    #12;
    check("rst_cs", spi_cs, 1);
    check("rst_clk", spi_clk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_dout", data_out, 16'h0000);
    @(negedge clk) reset = 1;
    repeat (2) @(negedge clk);

    foreach (v[i]) begin
      txn(v[i].addr, v[i].din, v[i].we, lat);
      check($sformatf("v%0d_latency", i), lat, 165);
      check($sformatf("v%0d_bits", i), mbits, 40);
      check($sformatf("v%0d_frame", i), cap, v[i].frame);
      check($sformatf("v%0d_busy_done", i), busy, 0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_dout", i), data_out, v[i].dout);
      check($sformatf("v%0d_ready_len", i), ready, 0);
      if (v[i].we) check($sformatf("v%0d_mem", i), mem[v[i].addr[14:0]], v[i].din);
    end

    r0 = readys; f0 = frames; hit = 0;
    @(negedge clk);
    address = 16'h0123; write_enable = 0; start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk);
      #1 start = (n == 10 || n == 100);
      if (ready) begin
        start = 1;
        @(posedge clk);
        #1 start = 0;
        hit = 1;
        break;
      end
    end
    check("ignore_done_seen", hit, 1);
    repeat (400) @(posedge clk);
    #1;
    check("ignore_frames", frames - f0, 1);
    check("ignore_readys", readys - r0, 1);
    check("ignore_busy", busy, 0);

    r0 = readys; hit = 0;
    @(negedge clk);
    address = 16'h7FFF; write_enable = 0; start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (mbits == 21) begin
        hit = 1;
        break;
      end
    end
    check("abort_reached_bit20", hit, 1);
    #2 reset = 0;
    #1;
    check("abort_cs", spi_cs, 1);
    check("abort_busy", busy, 0);
    check("abort_sclk", spi_clk, 0);
    repeat (3) @(negedge clk);
    reset = 1;
    repeat (200) @(negedge clk);
    check("abort_no_ready", readys - r0, 0);
    check("abort_dout_cleared", data_out, 16'h0000);
    txn(16'h0123, 16'h0000, 1'b0, lat);
    check("after_abort_latency", lat, 165);
    check("after_abort_frame", cap, {8'h03, 16'h0246, 16'h0000});
    @(posedge clk);
    #1;
    check("after_abort_dout", data_out, 16'hBEEF);

    meas(0, lat, per);
    check("div1_period", per, 2);
    check("div1_latency", lat, 83);
    meas(1, lat, per);
    check("div5_period", per, 10);
    check("div5_latency", lat, 411);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
